// File: rtl/receive_ordered_set_if.sv
// Code-group input and GMII-style receive output bundle for the
// receive ordered-set state machine.
interface receive_ordered_set_if;
    logic [7:0] rx_code;
    logic       rx_is_k;
    logic       rx_code_valid;
    logic       sync_status;
    logic [7:0] RXD;
    logic       RX_DV;
    logic       RX_ER;
    logic       receiving;
    logic       rx_even;

    // Receiver side: consumes code-groups, drives the data outputs
    modport slave (
        input  rx_code, rx_is_k, rx_code_valid, sync_status,
        output RXD, RX_DV, RX_ER, receiving, rx_even
    );

    // Source side: supplies code-groups, observes the data outputs
    modport master (
        output rx_code, rx_is_k, rx_code_valid, sync_status,
        input  RXD, RX_DV, RX_ER, receiving, rx_even
    );
endinterface

// File: rtl/receive_ordered_set.sv
// 1000BASE-X style receive ordered-set decoder. Consumes one decoded
// code-group per clock and produces registered RXD/RX_DV/RX_ER with one
// cycle of latency. rx_even is registered alongside the data, so it gives
// the parity of the code-group whose result is currently on RXD.
module receive_ordered_set #(
    parameter logic [7:0] K_COMMA = 8'hBC,
    parameter logic [7:0] D_IDLE2 = 8'h50,
    parameter logic [7:0] D_IDLE1 = 8'hC5,
    parameter logic [7:0] K_SOP   = 8'hFB,
    parameter logic [7:0] K_EOP   = 8'hFD,
    parameter logic [7:0] K_EXT   = 8'hF7
) (
    input  logic                  CLK,
    input  logic                  RESET,
    receive_ordered_set_if.slave  bus
);

    typedef enum logic [2:0] {
        LINK_FAILED,
        WAIT_FOR_K,
        RX_K,
        IDLE_D,
        RECEIVE,
        FALSE_CARRIER,
        TRI_RRI
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [7:0] r_rxd, w_rxd_nxt;
    logic       r_dv, w_dv_nxt;
    logic       r_er, w_er_nxt;
    logic       r_recv, w_recv_nxt;
    logic       r_even;
    logic       r_ext_seen, w_ext_seen_nxt;

    logic       w_k_comma, w_k_sop, w_k_eop, w_k_ext;
    logic       w_data, w_idle_d, w_even_pos;

    assign w_k_comma = bus.rx_code_valid && bus.rx_is_k && (bus.rx_code == K_COMMA);
    assign w_k_sop   = bus.rx_code_valid && bus.rx_is_k && (bus.rx_code == K_SOP);
    assign w_k_eop   = bus.rx_code_valid && bus.rx_is_k && (bus.rx_code == K_EOP);
    assign w_k_ext   = bus.rx_code_valid && bus.rx_is_k && (bus.rx_code == K_EXT);
    assign w_data    = bus.rx_code_valid && !bus.rx_is_k;
    assign w_idle_d  = w_data && ((bus.rx_code == D_IDLE1) || (bus.rx_code == D_IDLE2));
    // Parity of the code-group being sampled now, before any comma realignment
    assign w_even_pos = !r_even;

    // Next-state and next-output decode for the sampled code-group
    always_comb begin
        w_state_nxt    = r_state;
        w_rxd_nxt      = 8'h00;
        w_dv_nxt       = 1'b0;
        w_er_nxt       = 1'b0;
        w_recv_nxt     = 1'b0;
        w_ext_seen_nxt = r_ext_seen;
        if (!bus.sync_status) begin
            // Losing sync mid-frame flags the truncated frame with one error cycle
            w_state_nxt    = LINK_FAILED;
            w_er_nxt       = r_dv;
            w_ext_seen_nxt = 1'b0;
        end else begin
            case (r_state)
                LINK_FAILED: w_state_nxt = WAIT_FOR_K;
                WAIT_FOR_K: begin
                    if (w_k_comma) w_state_nxt = RX_K;
                end
                RX_K: begin
                    w_state_nxt = w_idle_d ? IDLE_D : WAIT_FOR_K;
                end
                IDLE_D: begin
                    if (w_k_comma) begin
                        w_state_nxt = RX_K;
                    end else if (w_k_sop) begin
                        w_state_nxt = RECEIVE;
                        w_rxd_nxt   = 8'h55;
                        w_dv_nxt    = 1'b1;
                        w_recv_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = FALSE_CARRIER;
                        w_rxd_nxt   = 8'h0E;
                        w_er_nxt    = 1'b1;
                        w_recv_nxt  = 1'b1;
                    end
                end
                RECEIVE: begin
                    if (w_data) begin
                        w_rxd_nxt  = bus.rx_code;
                        w_dv_nxt   = 1'b1;
                        w_recv_nxt = 1'b1;
                    end else if (w_k_eop) begin
                        w_state_nxt    = TRI_RRI;
                        w_recv_nxt     = 1'b1;
                        w_ext_seen_nxt = 1'b0;
                    end else if (w_k_comma) begin
                        // Early end: close the frame with a single error cycle
                        w_state_nxt = RX_K;
                        w_rxd_nxt   = bus.rx_code;
                        w_dv_nxt    = 1'b1;
                        w_er_nxt    = 1'b1;
                        w_recv_nxt  = 1'b1;
                    end else begin
                        w_rxd_nxt  = bus.rx_code;
                        w_dv_nxt   = 1'b1;
                        w_er_nxt   = 1'b1;
                        w_recv_nxt = 1'b1;
                    end
                end
                FALSE_CARRIER: begin
                    if (w_k_comma && w_even_pos) begin
                        w_state_nxt = RX_K;
                    end else begin
                        w_rxd_nxt  = 8'h0E;
                        w_er_nxt   = 1'b1;
                        w_recv_nxt = 1'b1;
                    end
                end
                TRI_RRI: begin
                    if (w_k_ext) begin
                        w_recv_nxt     = 1'b1;
                        w_ext_seen_nxt = 1'b1;
                    end else if (w_k_comma && r_ext_seen) begin
                        w_state_nxt = RX_K;
                    end else begin
                        // Malformed end-of-packet delimiter
                        w_state_nxt = WAIT_FOR_K;
                        w_rxd_nxt   = 8'h1F;
                        w_er_nxt    = 1'b1;
                    end
                end
                default: w_state_nxt = LINK_FAILED;
            endcase
        end
    end

    // State, output and parity registers; RESET wins over everything
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state    <= LINK_FAILED;
            r_rxd      <= 8'h00;
            r_dv       <= 1'b0;
            r_er       <= 1'b0;
            r_recv     <= 1'b0;
            r_even     <= 1'b1;
            r_ext_seen <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_rxd      <= w_rxd_nxt;
            r_dv       <= w_dv_nxt;
            r_er       <= w_er_nxt;
            r_recv     <= w_recv_nxt;
            r_even     <= w_k_comma ? 1'b1 : !r_even;
            r_ext_seen <= w_ext_seen_nxt;
        end
    end

    assign bus.RXD       = r_rxd;
    assign bus.RX_DV     = r_dv;
    assign bus.RX_ER     = r_er;
    assign bus.receiving = r_recv;
    assign bus.rx_even   = r_even;

endmodule
